// File: rtl/riscv_cache_fill_ctrl.sv
// rtl/riscv_cache_fill_ctrl.sv - cache hit/miss response stage with BIU line-fill burst
module riscv_cache_fill_ctrl #(
  parameter int XLEN       = 32,
  parameter int PLEN       = 32,
  parameter int BLOCK_SIZE = 256,
  parameter int WAYS       = 2,
  parameter int IDX_BITS   = 5,
  parameter int BEATS      = BLOCK_SIZE / XLEN,
  parameter int OFFS_BITS  = $clog2(BLOCK_SIZE / 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_i,
  input  logic [PLEN-1:0]       adr_i,
  input  logic                  pagefault_i,
  input  logic [WAYS-1:0]       hit_way_i,
  input  logic [BLOCK_SIZE-1:0] hit_line_i,
  input  logic [WAYS-1:0]       victim_way_i,
  output logic                  stall_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [XLEN-1:0]       q_o,
  output logic                  biu_stb_o,
  output logic [PLEN-1:0]       biu_adr_o,
  input  logic                  biu_stb_ack_i,
  input  logic                  biu_d_ack_i,
  input  logic [XLEN-1:0]       biu_q_i,
  input  logic                  biu_err_i,
  output logic                  fill_we_o,
  output logic [WAYS-1:0]       fill_way_o,
  output logic [IDX_BITS-1:0]   fill_idx_o,
  output logic [BLOCK_SIZE-1:0] fill_line_o
);

  localparam int WS_LSB = $clog2(XLEN / 8);
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BLOCK_SIZE-1:0]   buf_q;
  logic [PLEN-1:WS_LSB]    lad_q;
  logic [WAYS-1:0]         way_q;
  logic                    err_q;
  logic                    flush_q;

  logic [OFFS_BITS-1:WS_LSB] ws_in;
  logic [OFFS_BITS-1:WS_LSB] ws_q;
  logic                      miss;

  assign ws_in = adr_i[OFFS_BITS-1:WS_LSB];
  assign ws_q  = lad_q[OFFS_BITS-1:WS_LSB];
  assign miss  = req_i & ~pagefault_i & ~(|hit_way_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      lad_q   <= '0;
      way_q   <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            lad_q   <= adr_i[PLEN-1:WS_LSB];
            way_q   <= victim_way_i;
            err_q   <= 1'b0;
            flush_q <= flush_i;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (flush_i) flush_q <= 1'b1;
          if (biu_stb_ack_i) begin
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (flush_i) flush_q <= 1'b1;
          if (biu_d_ack_i) begin
            buf_q[XLEN*int'(cnt_q) +: XLEN] <= biu_q_i;
            err_q <= err_q | biu_err_i;
            // terminal beat detected by compare so a non-power-of-two BEATS still works
            if (cnt_q == CNT_W'(BEATS - 1)) begin
              cnt_q   <= '0;
              state_q <= WRITE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        WRITE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o     = 1'b0;
    ack_o       = 1'b0;
    err_o       = 1'b0;
    q_o         = '0;
    biu_stb_o   = 1'b0;
    biu_adr_o   = '0;
    fill_we_o   = 1'b0;
    fill_way_o  = '0;
    fill_idx_o  = '0;
    fill_line_o = '0;
    case (state_q)
      IDLE: begin
        // the hit path is combinational, so it is gated by reset to keep outputs quiet
        if (req_i && !rst_i) begin
          if (pagefault_i) begin
            ack_o = ~flush_i;
            err_o = 1'b1;
          end else if (|hit_way_i) begin
            ack_o = ~flush_i;
            q_o   = hit_line_i[XLEN*int'(ws_in) +: XLEN];
          end else begin
            stall_o = 1'b1;
          end
        end
      end
      REQ: begin
        stall_o   = 1'b1;
        biu_stb_o = 1'b1;
        biu_adr_o = {lad_q[PLEN-1:OFFS_BITS], {OFFS_BITS{1'b0}}};
      end
      FILL: stall_o = 1'b1;
      WRITE: begin
        fill_we_o   = ~err_q;
        fill_way_o  = way_q;
        fill_idx_o  = lad_q[OFFS_BITS +: IDX_BITS];
        fill_line_o = buf_q;
        ack_o       = ~flush_q;
        err_o       = err_q;
        q_o         = buf_q[XLEN*int'(ws_q) +: XLEN];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/riscv_cache_fill_ctrl.md
Name: riscv_cache_fill_ctrl

Overview:
- Hit/miss response stage that consumes the registered request presented by the cache tag stage.
- On a hit, returns the requested word to the core in the same cycle.
- On a miss, stalls the pipeline, fetches the whole line from the BIU as an incrementing burst, writes the line into the selected way, then responds.
- Read path only; write handling belongs to a separate write-buffer block.

Parameters:
- XLEN, 32, core data width.
- PLEN, 32, physical address width.
- BLOCK_SIZE, 256, cache line size in bits; must be a multiple of XLEN.
- WAYS, 2, associativity.
- IDX_BITS, 5, set-index width.
- BEATS, BLOCK_SIZE/XLEN (8), burst length in beats.
- OFFS_BITS, $clog2(BLOCK_SIZE/8) (5), line byte-offset width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  pipeline flush
- req_i  in  1  request valid, from tag stage
- adr_i  in  PLEN  physical address, from tag stage
- pagefault_i  in  1  request carries a page fault
- hit_way_i  in  WAYS  one-hot hit vector (all zero = miss)
- hit_line_i  in  BLOCK_SIZE  line read from the hitting way
- victim_way_i  in  WAYS  one-hot replacement way, valid with req_i
- stall_o  out  1  stalls the tag stage and upstream
- ack_o  out  1  response valid
- err_o  out  1  response error, qualified by ack_o
- q_o  out  XLEN  response data
- biu_stb_o  out  1  burst request
- biu_adr_o  out  PLEN  line-aligned burst address
- biu_stb_ack_i  in  1  burst request accepted
- biu_d_ack_i  in  1  read beat valid
- biu_q_i  in  XLEN  read beat data
- biu_err_i  in  1  beat error, qualified by biu_d_ack_i
- fill_we_o  out  1  line write strobe
- fill_way_o  out  WAYS  one-hot way to write
- fill_idx_o  out  IDX_BITS  set index to write
- fill_line_o  out  BLOCK_SIZE  assembled line

Behaviour:
- Reset values: state=IDLE; all outputs 0; beat counter 0; line buffer 0; captured address 0; error flag 0.

Definitions:
- word select: ws = adr[OFFS_BITS-1:$clog2(XLEN/8)]
- index: adr[OFFS_BITS +: IDX_BITS]

States and transitions:
- IDLE
  - req_i & pagefault_i: ack_o=1, err_o=1, q_o=0, combinational. No BIU activity, no stall.
  - req_i & |hit_way_i (no page fault): ack_o=1, err_o=0, q_o=hit_line_i word ws, combinational, zero added latency. No stall.
  - req_i & miss: stall_o=1 combinationally. Capture adr_i, victim_way_i and ws. Go to REQ.
- REQ
  - biu_stb_o=1, biu_adr_o = captured adr with low OFFS_BITS cleared.
  - Hold both until biu_stb_ack_i, then go to FILL with the beat counter at 0.
- FILL
  - Each biu_d_ack_i stores biu_q_i into buffer word[counter], increments the counter, and ORs biu_err_i into the error flag.
  - After beat BEATS-1, go to WRITE.
  - Beats without biu_d_ack_i are wait cycles with no change.
- WRITE, one cycle:
  - fill_we_o=1 only if the error flag is clear.
  - fill_way_o = captured way, fill_idx_o = captured index, fill_line_o = buffer.
  - ack_o=1, err_o=error flag, q_o = buffer word ws; ack_o is suppressed if the flush flag is set.
  - Go to IDLE.
- stall_o=1 in REQ and FILL; it drops in WRITE, so the ack coincides with the pipeline advancing.

Boundary conditions:
- flush_i during REQ or FILL
  - Sets the flush flag.
  - The burst always completes (the BIU cannot abort it).
  - The line is still written if error-free; ack_o is suppressed.
- flush_i in IDLE: hit and page-fault acks are suppressed the same cycle.
- biu_err_i on any beat: the remaining beats are still counted; no fill write; err_o=1.
- biu_d_ack_i in IDLE or REQ is ignored.
- A beat arriving in the same cycle as biu_stb_ack_i is not counted; the BIU must deliver beats from the next cycle.
- Request in WRITE: not sampled; the tag stage re-presents it in the following IDLE cycle.
- hit_way_i with more than one bit set is illegal; the lowest set way is used.
- The beat counter is $clog2(BEATS) bits wide; the terminal beat is detected by counter==BEATS-1, not by overflow.
- rst_i mid-burst: immediate return to IDLE with all outputs 0. The BIU is reset concurrently.

Test Plan:
- Hit:
  - Stimulus: req_i=1, adr_i=0x0000_1014, hit_way_i=2'b01, hit_line_i word5=0xDEADBEEF.
  - Response: same-cycle ack_o=1, q_o=0xDEADBEEF, stall_o=0.
- Miss:
  - Stimulus: adr_i=0x0000_2048, victim 2'b10. BIU accepts after 3 cycles, returns beats 0x100..0x107 with one wait cycle between beats 3 and 4.
  - Response: biu_adr_o=0x0000_2040. In WRITE: fill_we_o=1, fill_idx_o=2, fill_way_o=2'b10, ack_o=1, q_o=0x102. stall_o high from miss until WRITE.
- Beat error:
  - Stimulus: miss with biu_err_i set on beat 6.
  - Response: all 8 beats consumed, fill_we_o stays 0, ack_o=1 with err_o=1.
- Flush mid-fill:
  - Stimulus: flush_i pulsed during beat 2.
  - Response: burst completes, fill_we_o=1, no ack_o, back in IDLE after WRITE.
- Page fault:
  - Stimulus: req_i=1, pagefault_i=1, hit_way_i=0.
  - Response: ack_o=1, err_o=1, biu_stb_o never asserted.
- Reset:
  - Stimulus: rst_i asserted during FILL beat 4.
  - Response: all outputs 0 asynchronously. A following miss request restarts a clean burst with the counter at 0.
